// File: rtl/mem_stage.sv
// MEM stage: holds one instruction, waits for its data-SRAM response, aligns/extends load data, forwards to WB.
// Results leave combinationally in the response cycle; back-pressure from WB parks the response in rdata_buf_q.
module mem_stage #(
  parameter int WB_BUS_W  = 211,
  parameter int EXE_BUS_W = WB_BUS_W + 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 EXE_to_MEM_valid,
  input  logic [EXE_BUS_W-1:0] EXE_to_MEM_bus,
  output logic                 MEM_allow,
  output logic                 MEM_to_WB_valid,
  output logic [WB_BUS_W-1:0]  MEM_to_WB_bus,
  input  logic                 WB_allow,
  input  logic                 flush,
  input  logic                 es_req_outstanding,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic [4:0]           MEM_dest_bus,
  output logic [31:0]          MEM_value_bus,
  output logic                 MEM_load_pending,
  output logic                 MEM_ex
);

  localparam int RFM_BIT = EXE_BUS_W - 1;
  localparam int REQ_BIT = EXE_BUS_W - 2;
  localparam int LT_HI   = EXE_BUS_W - 3;
  localparam int AL_HI   = EXE_BUS_W - 6;
  localparam int EX_BIT  = WB_BUS_W;
  localparam int RES_HI  = 204;
  localparam int RES_LO  = 173;

  logic                 mem_valid_q, mem_valid_d;
  logic [EXE_BUS_W-1:0] bus_q, bus_d;
  logic                 got_resp_q, got_resp_d;
  logic [31:0]          rdata_buf_q, rdata_buf_d;
  logic [1:0]           drop_cnt_q, drop_cnt_d;

  logic                res_from_mem, req_issued, any_ex;
  logic [2:0]          ld_type;
  logic [1:0]          addr_lo;
  logic [WB_BUS_W-1:0] payload, payload_adj;
  logic                wait_resp, resp_hit, mem_go, leave;
  logic [31:0]         word, shifted, ld_res;
  logic [15:0]         half;
  logic [2:0]          drop_sum;

  assign res_from_mem = bus_q[RFM_BIT];
  assign req_issued   = bus_q[REQ_BIT];
  assign ld_type      = bus_q[LT_HI -: 3];
  assign addr_lo      = bus_q[AL_HI -: 2];
  assign any_ex       = bus_q[EX_BIT];
  assign payload      = bus_q[WB_BUS_W-1:0];

  assign wait_resp = mem_valid_q & res_from_mem & req_issued & ~any_ex & ~got_resp_q;
  assign resp_hit  = data_sram_data_ok & (drop_cnt_q == 2'd0) & wait_resp;
  assign mem_go    = ~wait_resp | resp_hit;
  assign leave     = mem_valid_q & mem_go & WB_allow;

  assign MEM_allow        = ~mem_valid_q | (mem_go & WB_allow);
  assign MEM_to_WB_valid  = mem_valid_q & mem_go & ~flush;
  assign MEM_to_WB_bus    = payload_adj;
  assign MEM_dest_bus     = (mem_valid_q & payload[210]) ? payload[209:205] : 5'd0;
  assign MEM_value_bus    = payload_adj[RES_HI:RES_LO];
  assign MEM_load_pending = wait_resp & ~resp_hit;
  assign MEM_ex           = mem_valid_q & any_ex;

  always_comb begin
    word    = got_resp_q ? rdata_buf_q : data_sram_rdata;
    shifted = word >> {addr_lo, 3'b000};
    half    = addr_lo[1] ? word[31:16] : word[15:0];
    case (ld_type)
      3'b001:  ld_res = {{24{shifted[7]}}, shifted[7:0]};
      3'b010:  ld_res = {24'd0, shifted[7:0]};
      3'b011:  ld_res = {{16{half[15]}}, half};
      3'b100:  ld_res = {16'd0, half};
      default: ld_res = word;
    endcase
    payload_adj = payload;
    if (res_from_mem & ~any_ex) payload_adj[RES_HI:RES_LO] = ld_res;
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    if (flush)          mem_valid_d = 1'b0;
    else if (MEM_allow) mem_valid_d = EXE_to_MEM_valid;

    bus_d = bus_q;
    if (EXE_to_MEM_valid & MEM_allow) bus_d = EXE_to_MEM_bus;

    got_resp_d  = got_resp_q;
    rdata_buf_d = rdata_buf_q;
    if (flush) begin
      got_resp_d = 1'b0;
    end else if (resp_hit & ~WB_allow) begin
      got_resp_d  = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end else if (leave) begin
      got_resp_d = 1'b0;
    end

    // Count responses still in flight for killed requests; each is swallowed on arrival.
    drop_sum = {1'b0, drop_cnt_q} - {2'b00, (data_sram_data_ok & (drop_cnt_q != 2'd0))};
    if (flush) begin
      drop_sum = drop_sum + {2'b00, (wait_resp & ~resp_hit)} + {2'b00, es_req_outstanding};
    end
    drop_cnt_d = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      got_resp_q  <= 1'b0;
      rdata_buf_q <= 32'd0;
      drop_cnt_q  <= 2'd0;
    end else begin
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      got_resp_q  <= got_resp_d;
      rdata_buf_q <= rdata_buf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
